program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- UART-side control block directly upstream of the MIPS core.
- Consumes received bytes from the UART receiver: one byte plus a one-cycle done tick per byte.
- Decodes single-byte commands and assembles 32-bit instruction words for the core's instruction memory, writing them one per write pulse.
- Gates the core through stall and reset lines, providing load, run, single-step and halt control.

Parameters:
- SIZE, 32, instruction/data word width (fixed 32; four bytes per word).
- MAX_INSTRUCTION, 64, instruction memory depth in words.
- ADDR_WIDTH, $clog2(MAX_INSTRUCTION), instruction memory address width.
- HALT_WORD, 32'hFFFFFFFF, end-of-program marker word.

Ports:
- i_clk  in  1  system clock (core clock domain).
- i_rst  in  1  asynchronous reset, active-high.
- i_rx_data  in  8  byte from UART receiver; valid only when i_rx_done=1.
- i_rx_done  in  1  one-cycle tick: i_rx_data holds a new byte.
- o_imem_we  out  1  instruction memory write enable (one-cycle pulse).
- o_imem_addr  out  ADDR_WIDTH  instruction memory word address.
- o_imem_data  out  SIZE  instruction word to write.
- o_cpu_stall  out  1  1 = core frozen.
- o_cpu_rst  out  1  1 = core pipeline/PC held in reset.
- o_load_done  out  1  1 = valid program resident.
- o_instr_count  out  ADDR_WIDTH+1  words written by last load, including the marker.
- o_state  out  3  current FSM state encoding, for debug/LEDs.

Behaviour:
- Reset values (async, i_rst=1):
  - state=IDLE; o_imem_we=0, o_imem_addr=0, o_imem_data=0.
  - o_cpu_stall=1, o_cpu_rst=1, o_load_done=0, o_instr_count=0.
  - Byte counter = 0.
  - Memory contents are not cleared.
- Commands are recognised only in IDLE or RUN:
  - 'L'=0x4C load, 'R'=0x52 run, 'S'=0x53 step, 'H'=0x48 halt.
  - All other bytes are ignored; no state change.
- States: IDLE=0, LOAD=1, WRITE=2, RUN=3, STEP=4.
- IDLE:
  - Outputs: o_cpu_stall=1; o_cpu_rst=0 unless a load is incomplete.
  - 'L' -> LOAD. Next cycle: addr=0, byte counter=0, o_instr_count=0, o_load_done=0, o_cpu_rst=1.
  - 'R' -> RUN, only if o_load_done=1; otherwise ignored.
  - 'S' -> STEP, only if o_load_done=1; otherwise ignored.
  - 'H' -> no effect.
- LOAD:
  - Outputs: o_cpu_stall=1, o_cpu_rst=1.
  - Each i_rx_done stores i_rx_data into byte lane k of the word buffer (bits 8k+7:8k, little-endian); k = byte counter 0..3.
  - Command decoding is disabled; every byte is data.
  - On the 4th byte, the counter wraps to 0 and the FSM moves to WRITE.
- WRITE (exactly one cycle):
  - o_imem_we=1, o_imem_data=assembled word, o_imem_addr=current address.
  - The same cycle increments o_instr_count.
  - Next state:
    - Word == HALT_WORD, or address == MAX_INSTRUCTION-1: -> IDLE; o_load_done=1, o_cpu_rst=0. The address does not increment.
    - Otherwise: address+1 -> LOAD.
  - An i_rx_done coincident with WRITE is captured as lane 0 of the next word; no byte is lost.
- RUN:
  - Outputs: o_cpu_stall=0, o_cpu_rst=0.
  - 'H' -> IDLE (stall=1 from the next cycle).
  - 'L' -> LOAD, the same as from IDLE.
  - Other bytes are ignored.
- STEP:
  - o_cpu_stall=0 for exactly one clock, then -> IDLE with stall=1.
  - An rx tick during STEP is ignored.
- o_imem_we is 0 in every state except WRITE.
- All outputs are registered; commands take effect on the clock after i_rx_done.
- Reset mid-load:
  - Partial word discarded, o_load_done=0.
  - Words already written remain in memory but are considered invalid.
- o_instr_count saturates at MAX_INSTRUCTION (needs ADDR_WIDTH+1 bits).

Test Plan:
1. Reset then bytes 'R' and 'S' with no program -> state stays IDLE (0), o_cpu_stall=1, o_load_done=0.
2. 'L', then bytes 13 00 01 20, then FF FF FF FF -> two WRITE pulses:
   - addr 0 data 0x20010013;
   - addr 1 data 0xFFFFFFFF.
   - Then IDLE, o_load_done=1, o_instr_count=2, o_cpu_rst=0.
3. After scenario 2, send 'R' -> o_cpu_stall=0 from the next clock and held. Then 'H' -> stall=1 one clock after the tick, state IDLE.
4. After scenario 2, send 'S' three times -> exactly three isolated one-cycle stall=0 windows, state back to IDLE each time.
5. 'L' then 256 non-marker bytes (64 words) -> 64 WRITE pulses, addresses 0..63. Load terminates at addr 63 with o_instr_count=64 and o_load_done=1. A further byte is ignored and causes no WRITE.
6. Async reset asserted mid-load after 2 words + 2 bytes -> all outputs take reset values immediately. After release, a new 'L' load starts at addr 0 with lane 0.

Source files
------------

// File: rtl/program_loader.sv
// UART-driven program loader: assembles little-endian instruction words into instruction memory
// and gates the core through stall/reset for load, run, single-step and halt.
module program_loader #(
    parameter int unsigned    SIZE            = 32,
    parameter int unsigned    MAX_INSTRUCTION = 64,
    parameter int unsigned    ADDR_WIDTH      = $clog2(MAX_INSTRUCTION),
    parameter logic [SIZE-1:0] HALT_WORD      = 32'hFFFF_FFFF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_done,
    output logic                  o_imem_we,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    output logic [SIZE-1:0]       o_imem_data,
    output logic                  o_cpu_stall,
    output logic                  o_cpu_rst,
    output logic                  o_load_done,
    output logic [ADDR_WIDTH:0]   o_instr_count,
    output logic [2:0]            o_state
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StWrite = 3'd2,
        StRun   = 3'd3,
        StStep  = 3'd4
    } state_e;

    state_e          state, next_state;
    logic [1:0]      byte_cnt;
    logic [SIZE-1:0] word_buf, word_next;
    logic            cmd_load, cmd_run, cmd_step, cmd_halt;
    logic            write_last, start_load;
    logic            imem_we_next, cpu_stall_next;

    assign cmd_load = i_rx_done && (i_rx_data == 8'h4C);
    assign cmd_run  = i_rx_done && (i_rx_data == 8'h52);
    assign cmd_step = i_rx_done && (i_rx_data == 8'h53);
    assign cmd_halt = i_rx_done && (i_rx_data == 8'h48);

    // Load ends on the marker word or when the last memory slot has been written.
    assign write_last = (word_buf == HALT_WORD) ||
                        (o_imem_addr == ADDR_WIDTH'(MAX_INSTRUCTION - 1));
    assign start_load = cmd_load && (state == StIdle || state == StRun);
    assign o_state    = state;

    always_comb begin
        word_next = word_buf;
        word_next[{byte_cnt, 3'b000} +: 8] = i_rx_data;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= StIdle;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            StIdle: begin
                if (cmd_load) begin
                    next_state = StLoad;
                end else if (cmd_run && o_load_done) begin
                    next_state = StRun;
                end else if (cmd_step && o_load_done) begin
                    next_state = StStep;
                end
            end
            StLoad: begin
                if (i_rx_done && byte_cnt == 2'd3) begin
                    next_state = StWrite;
                end
            end
            StWrite: next_state = write_last ? StIdle : StLoad;
            StRun: begin
                if (cmd_halt) begin
                    next_state = StIdle;
                end else if (cmd_load) begin
                    next_state = StLoad;
                end
            end
            StStep:  next_state = StIdle;
            default: next_state = StIdle;
        endcase
    end

    // Registered outputs are decoded from the state being entered.
    always_comb begin
        imem_we_next   = (next_state == StWrite);
        cpu_stall_next = !(next_state == StRun || next_state == StStep);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_imem_we     <= 1'b0;
            o_imem_addr   <= '0;
            o_imem_data   <= '0;
            o_cpu_stall   <= 1'b1;
            o_cpu_rst     <= 1'b1;
            o_load_done   <= 1'b0;
            o_instr_count <= '0;
            byte_cnt      <= 2'd0;
            word_buf      <= '0;
        end else begin
            o_imem_we   <= imem_we_next;
            o_cpu_stall <= cpu_stall_next;
            if (start_load) begin
                o_imem_addr   <= '0;
                o_instr_count <= '0;
                o_load_done   <= 1'b0;
                o_cpu_rst     <= 1'b1;
                byte_cnt      <= 2'd0;
            end
            if (state == StLoad && i_rx_done) begin
                word_buf <= word_next;
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) begin
                    o_imem_data <= word_next;
                    if (o_instr_count < (ADDR_WIDTH + 1)'(MAX_INSTRUCTION)) begin
                        o_instr_count <= o_instr_count + 1'b1;
                    end
                end
            end
            if (state == StWrite) begin
                if (write_last) begin
                    o_load_done <= 1'b1;
                    o_cpu_rst   <= 1'b0;
                end else begin
                    o_imem_addr <= o_imem_addr + 1'b1;
                    // A byte arriving during the write cycle opens the next word.
                    if (i_rx_done) begin
                        word_buf[7:0] <= i_rx_data;
                        byte_cnt      <= 2'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: command vector tables plus a write scoreboard fed by the byte driver.
module tb_program_loader;
    localparam int unsigned AW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_done = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_data;
    logic          cpu_stall, cpu_rst, load_done;
    logic [AW:0]   instr_count;
    logic [2:0]    state;

    program_loader dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rx_data    (rx_data),
        .i_rx_done    (rx_done),
        .o_imem_we    (imem_we),
        .o_imem_addr  (imem_addr),
        .o_imem_data  (imem_data),
        .o_cpu_stall  (cpu_stall),
        .o_cpu_rst    (cpu_rst),
        .o_load_done  (load_done),
        .o_instr_count(instr_count),
        .o_state      (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    typedef struct {
        logic [7:0] b;
        logic [2:0] st;
        logic       stall;
        logic       ld;
    } vec_t;

    wr_t           exp_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    int            n_wr = 0;
    logic [AW-1:0] model_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Caller sits on a negedge; consecutive calls give back-to-back rx ticks.
    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic send_word(input logic [31:0] w);
        wr_t e;
        e.addr = model_addr;
        e.data = w;
        exp_q.push_back(e);
        model_addr = model_addr + 1'b1;
        for (int k = 0; k < 4; k++) send(w[8*k +: 8]);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, 32'(state), 0);
        check({tag, "_we"}, 32'(imem_we), 0);
        check({tag, "_addr"}, 32'(imem_addr), 0);
        check({tag, "_data"}, imem_data, 0);
        check({tag, "_stall"}, 32'(cpu_stall), 1);
        check({tag, "_cpu_rst"}, 32'(cpu_rst), 1);
        check({tag, "_load_done"}, 32'(load_done), 0);
        check({tag, "_count"}, 32'(instr_count), 0);
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (imem_we === 1'b1) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: addr %0d data 0x%h, no write required",
                         imem_addr, imem_data);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", 32'(imem_addr), 32'(e.addr));
                check("write_data", imem_data, e.data);
                check("write_stall", 32'(cpu_stall), 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tab_a[4];
        vec_t tab_b[6];
        int   n0;
        logic [31:0] w;

        // No program resident: run/step/halt and junk are all ignored.
        tab_a[0] = '{8'h52, 3'd0, 1'b1, 1'b0};
        tab_a[1] = '{8'h53, 3'd0, 1'b1, 1'b0};
        tab_a[2] = '{8'h48, 3'd0, 1'b1, 1'b0};
        tab_a[3] = '{8'h00, 3'd0, 1'b1, 1'b0};
        // Program resident: run, ignored bytes while running, halt.
        tab_b[0] = '{8'h52, 3'd3, 1'b0, 1'b1};
        tab_b[1] = '{8'h00, 3'd3, 1'b0, 1'b1};
        tab_b[2] = '{8'h53, 3'd3, 1'b0, 1'b1};
        tab_b[3] = '{8'h52, 3'd3, 1'b0, 1'b1};
        tab_b[4] = '{8'h48, 3'd0, 1'b1, 1'b1};
        tab_b[5] = '{8'h48, 3'd0, 1'b1, 1'b1};

        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            send(tab_a[i].b);
            check($sformatf("idle_vec%0d_state", i), 32'(state), 32'(tab_a[i].st));
            check($sformatf("idle_vec%0d_stall", i), 32'(cpu_stall), 32'(tab_a[i].stall));
            check($sformatf("idle_vec%0d_load_done", i), 32'(load_done), 32'(tab_a[i].ld));
        end

        // Two-word program ending in the marker.
        model_addr = '0;
        send(8'h4C);
        check("load_state", 32'(state), 1);
        check("load_cpu_rst", 32'(cpu_rst), 1);
        send_word(32'h2001_0013);
        send_word(32'hFFFF_FFFF);
        wait_cycles(2);
        check("load2_pending", 32'(exp_q.size()), 0);
        check("load2_state", 32'(state), 0);
        check("load2_load_done", 32'(load_done), 1);
        check("load2_count", 32'(instr_count), 2);
        check("load2_cpu_rst", 32'(cpu_rst), 0);
        check("load2_stall", 32'(cpu_stall), 1);

        for (int i = 0; i < 6; i++) begin
            send(tab_b[i].b);
            check($sformatf("run_vec%0d_state", i), 32'(state), 32'(tab_b[i].st));
            check($sformatf("run_vec%0d_stall", i), 32'(cpu_stall), 32'(tab_b[i].stall));
            check($sformatf("run_vec%0d_load_done", i), 32'(load_done), 32'(tab_b[i].ld));
        end

        // Single steps: one stall-free clock each, then back to idle.
        for (int i = 0; i < 3; i++) begin
            send(8'h53);
            check($sformatf("step%0d_state", i), 32'(state), 4);
            check($sformatf("step%0d_stall", i), 32'(cpu_stall), 0);
            wait_cycles(1);
            check($sformatf("step%0d_idle_state", i), 32'(state), 0);
            check($sformatf("step%0d_idle_stall", i), 32'(cpu_stall), 1);
            wait_cycles(1);
        end
        // A tick landing in the step cycle is dropped.
        send(8'h53);
        send(8'h52);
        check("step_rx_state", 32'(state), 0);
        check("step_rx_stall", 32'(cpu_stall), 1);

        // Full 64-word load with no marker; terminates at the last address.
        n0 = n_wr;
        model_addr = '0;
        send(8'h4C);
        for (int wd = 0; wd < 64; wd++) begin
            for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'((wd * 4 + k) % 251);
            send_word(w);
        end
        wait_cycles(2);
        check("full_writes", 32'(n_wr - n0), 64);
        check("full_pending", 32'(exp_q.size()), 0);
        check("full_count", 32'(instr_count), 64);
        check("full_load_done", 32'(load_done), 1);
        check("full_state", 32'(state), 0);
        check("full_addr", 32'(imem_addr), 63);
        check("full_cpu_rst", 32'(cpu_rst), 0);
        send(8'h12);
        wait_cycles(2);
        check("extra_byte_writes", 32'(n_wr - n0), 64);
        check("extra_byte_state", 32'(state), 0);

        // Asynchronous reset two words and two bytes into a load.
        model_addr = '0;
        send(8'h4C);
        send_word(32'h1122_3344);
        send_word(32'h5566_7788);
        send(8'hAA);
        send(8'hBB);
        #2 rst = 1'b1;
        #1;
        check_reset_values("midload_reset");
        check("midload_pending", 32'(exp_q.size()), 0);
        @(negedge clk);
        rst = 1'b0;
        model_addr = '0;
        send(8'h4C);
        check("reload_state", 32'(state), 1);
        send_word(32'hCAFE_F00D);
        wait_cycles(2);
        check("reload_pending", 32'(exp_q.size()), 0);
        check("reload_count", 32'(instr_count), 1);
        check("reload_state_after", 32'(state), 1);
        check("reload_load_done", 32'(load_done), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
